hiscore_ram_port: RTL and testbench
===================================

HISCORE_RAM_PORT -- requirements
Module: hiscore_ram_port

Interface
REQ-001 Parameter AW, default 11: work-RAM address width (2 KB).
REQ-002 Parameter DW, default 8: data width.
REQ-003 Parameter SETTLE, default 2: idle cycles between the CPU stopping and the hiscore grant.
REQ-004 Parameter TIMEOUT_CYCLES, default 1048576: limit on hiscore ownership (used only with the macro).
REQ-005 Clock and reset are decided: one clock `clk_sys`; reset `reset` is synchronous and active-high.
REQ-006 Ports, one per line (name, direction, width, meaning):
- clk_sys  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- cpu_ce  in  1  CPU bus-cycle strobe, one clk_sys wide.
- cpu_cs  in  1  CPU selects work RAM.
- cpu_we  in  1  CPU write.
- cpu_addr  in  AW  CPU address.
- cpu_din  in  DW  CPU write data.
- cpu_dout  out  DW  RAM read data to the CPU.
- cpu_hold  out  1  pause request to the CPU core.
- hs_access  in  1  hiscore requests RAM ownership.
- hs_address  in  AW  hiscore address.
- hs_data_in  in  DW  hiscore write data.
- hs_write  in  1  hiscore write strobe.
- hs_data_out  out  DW  read data to the hiscore.
- hs_ready  out  1  hiscore owns RAM.
- hs_timeout  out  1  ownership was force-revoked (sticky).

Function
REQ-007 States: IDLE, DRAIN, GRANT, RELEASE; the state is registered.
- IDLE: CPU drives the RAM; cpu_hold=0; hs_ready=0.
- IDLE -> DRAIN: on hs_access=1; cpu_hold=1 from the next cycle.
- DRAIN -> GRANT: after the first cpu_ce pulse seen in DRAIN, the block waits SETTLE further cycles, then enters GRANT.
- DRAIN -> RELEASE: on hs_access=0 before the grant.
- GRANT: RAM address = hs_address, write enable = hs_write, write data = hs_data_in; hs_ready=1.
- GRANT -> RELEASE: on hs_access=0.
- RELEASE: one cycle; hs_ready=0; cpu_hold=1. Then -> IDLE, where cpu_hold=0.
REQ-008 The RAM is synchronous-read. hs_data_out is valid 1 cycle after hs_address is presented in GRANT; cpu_dout is valid 1 cycle after the CPU address.
REQ-009 A write takes effect in the cycle the strobe is sampled; a read in the same cycle returns the old data (read-before-write).
REQ-010 CPU writes are gated off in DRAIN, GRANT and RELEASE. When the CPU does not own the RAM, cpu_dout holds its last value.
REQ-011 hs_write outside GRANT is ignored, with no RAM change.
REQ-012 When hs_access and cpu_ce/cpu_we coincide in IDLE, the CPU write completes and the transition to DRAIN still occurs.
REQ-013 Address and data are passed through at full width, with no truncation or wrap inside the block.

Reset
REQ-014 Reset forces IDLE from any state, including mid-GRANT.
REQ-015 Reset values: cpu_hold=0, hs_ready=0, hs_timeout=0, hs_data_out=0, cpu_dout=0, settle/timeout counters=0.
REQ-016 RAM contents are not cleared by reset.

Configuration
REQ-017 Macro HISCORE_RAM_PORT_TIMEOUT_EN.
- Defined: a counter runs in DRAIN and GRANT. On reaching TIMEOUT_CYCLES the block forces RELEASE and sets hs_timeout. hs_timeout clears when hs_access=0. No new DRAIN starts while hs_timeout=1.
- Undefined: there is no counter, hs_timeout is tied to 0, and ownership is unlimited.

Structure
REQ-018 The shared package holds the state enum (IDLE, DRAIN, GRANT, RELEASE) and the default AW, DW, SETTLE and TIMEOUT_CYCLES constants.
REQ-019 The RAM is one sub-module, `spram`: single-port, synchronous read, AW x DW. It is instantiated once and fed by the owner mux.

Verification
REQ-020 Bench scenarios, one per line (stimulus -> required response):
- Handoff: hs_access=1 in IDLE, cpu_ce pulse 3 cycles later, SETTLE=2 -> cpu_hold=1 next cycle; hs_ready=1 exactly 3 cycles after the cpu_ce pulse.
- Read/write: in GRANT, write 0xA5 @0x7FF, then read 0x7FF -> hs_data_out=0xA5 one cycle after the read address; after release the CPU reads 0x7FF -> cpu_dout=0xA5.
- Gating: CPU writes 0x3C @0x010 during GRANT; hs_write=1 in IDLE @0x020 -> both locations are unchanged.
- Abort: hs_access drops during DRAIN -> RELEASE for 1 cycle, then IDLE; hs_ready never asserts.
- Reset mid-GRANT -> next cycle IDLE with cpu_hold=0 and hs_ready=0; RAM data written earlier is preserved.
- Timeout (macro defined, TIMEOUT_CYCLES=16): hs_access held high -> forced RELEASE after 16 cycles; hs_timeout=1 until hs_access=0; no re-grant meanwhile.

Source files
------------

// File: rtl/hiscore_ram_port_pkg.sv
// Shared types and default sizing for the hiscore work-RAM arbitration port.
package hiscore_ram_port_pkg;
   typedef enum logic [1:0] {IDLE, DRAIN, GRANT, RELEASE} hs_state_e;

   localparam int DEF_AW             = 11;
   localparam int DEF_DW             = 8;
   localparam int DEF_SETTLE         = 2;
   localparam int DEF_TIMEOUT_CYCLES = 1048576;
endpackage

// File: rtl/hiscore_ram_port_spram.sv
// Single-port work RAM, synchronous read, read-before-write on the shared address.
module spram #(
   parameter int AW = 11,
   parameter int DW = 8
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_din,
   output logic [DW-1:0] o_q
);
   logic [DW-1:0] r_mem [0:(1<<AW)-1];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_din;
      o_q <= r_mem[i_addr];
   end
endmodule

// File: rtl/hiscore_ram_port.sv
// Hands the work RAM from the CPU to the hiscore engine once the CPU has paused.
// Optional ownership limit: define HISCORE_RAM_PORT_TIMEOUT_EN.
module hiscore_ram_port
   import hiscore_ram_port_pkg::*;
#(
   parameter int AW             = DEF_AW,
   parameter int DW             = DEF_DW,
   parameter int SETTLE         = DEF_SETTLE,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          cpu_ce,
   input  logic          cpu_cs,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   output logic [DW-1:0] cpu_dout,
   output logic          cpu_hold,
   input  logic          hs_access,
   input  logic [AW-1:0] hs_address,
   input  logic [DW-1:0] hs_data_in,
   input  logic          hs_write,
   output logic [DW-1:0] hs_data_out,
   output logic          hs_ready,
   output logic          hs_timeout
);
   localparam int SW = $clog2(SETTLE + 2);

   hs_state_e     r_state, w_next;
   logic          r_seen;
   logic [SW-1:0] r_settle;
   logic          w_settle_done, w_to_hit, w_to_block;
   logic [AW-1:0] w_ram_addr;
   logic [DW-1:0] w_ram_din, w_ram_q;
   logic          w_ram_we;
   logic          r_cpu_own, r_hs_own;
   logic [DW-1:0] r_cpu_last, r_hs_last;

   always_ff @(posedge clk_sys) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Settle window opens on the first CPU strobe seen while draining.
   always_ff @(posedge clk_sys) begin
      if (reset || r_state != DRAIN) begin
         r_seen   <= 1'b0;
         r_settle <= '0;
      end else if (!r_seen) begin
         r_seen <= cpu_ce;
      end else begin
         r_settle <= r_settle + 1'b1;
      end
   end

   assign w_settle_done = (r_seen && (int'(r_settle) + 1 >= SETTLE)) ||
                          (!r_seen && cpu_ce && SETTLE == 0);

`ifdef HISCORE_RAM_PORT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_to_cnt;
   logic          r_timeout;

   always_ff @(posedge clk_sys) begin
      if (reset || !(r_state == DRAIN || r_state == GRANT)) r_to_cnt <= '0;
      else                                                  r_to_cnt <= r_to_cnt + 1'b1;
   end

   always_ff @(posedge clk_sys) begin
      if (reset || !hs_access) r_timeout <= 1'b0;
      else if (w_to_hit)       r_timeout <= 1'b1;
   end

   assign w_to_hit   = (r_state == DRAIN || r_state == GRANT) &&
                       (int'(r_to_cnt) + 1 >= TIMEOUT_CYCLES);
   assign w_to_block = r_timeout;
   assign hs_timeout = r_timeout;
`else
   assign w_to_hit   = 1'b0;
   assign w_to_block = 1'b0;
   assign hs_timeout = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (hs_access && !w_to_block) w_next = DRAIN;
         DRAIN:   if (!hs_access || w_to_hit)   w_next = RELEASE;
                  else if (w_settle_done)       w_next = GRANT;
         GRANT:   if (!hs_access || w_to_hit)   w_next = RELEASE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      cpu_hold   = (r_state != IDLE);
      hs_ready   = (r_state == GRANT);
      w_ram_addr = cpu_addr;
      w_ram_din  = cpu_din;
      w_ram_we   = (r_state == IDLE) && cpu_ce && cpu_cs && cpu_we;
      if (r_state == GRANT) begin
         w_ram_addr = hs_address;
         w_ram_din  = hs_data_in;
         w_ram_we   = hs_write;
      end
   end

   spram #(.AW(AW), .DW(DW)) u_ram (
      .i_clk  (clk_sys),
      .i_we   (w_ram_we),
      .i_addr (w_ram_addr),
      .i_din  (w_ram_din),
      .o_q    (w_ram_q)
   );

   // Each side sees live RAM data only for reads it issued while owning the RAM.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_cpu_own  <= 1'b0;
         r_hs_own   <= 1'b0;
         r_cpu_last <= '0;
         r_hs_last  <= '0;
      end else begin
         r_cpu_own <= (r_state == IDLE);
         r_hs_own  <= (r_state == GRANT);
         if (r_cpu_own) r_cpu_last <= w_ram_q;
         if (r_hs_own)  r_hs_last  <= w_ram_q;
      end
   end

   assign cpu_dout    = r_cpu_own ? w_ram_q : r_cpu_last;
   assign hs_data_out = r_hs_own  ? w_ram_q : r_hs_last;
endmodule

// File: tb/tb_hiscore_ram_port.sv
// Scoreboarded bench for hiscore_ram_port: reference memory model plus handoff timing checks.
module tb_hiscore_ram_port;
   localparam int AW = 11, DW = 8, SETTLE = 2;
`ifdef HISCORE_RAM_PORT_TIMEOUT_EN
   localparam int TOC = 16;
`else
   localparam int TOC = 1048576;
`endif

   logic          clk_sys = 1'b0, reset;
   logic          cpu_ce, cpu_cs, cpu_we, cpu_hold;
   logic [AW-1:0] cpu_addr, hs_address;
   logic [DW-1:0] cpu_din, cpu_dout, hs_data_in, hs_data_out;
   logic          hs_access, hs_write, hs_ready, hs_timeout;

   hiscore_ram_port #(.AW(AW), .DW(DW), .SETTLE(SETTLE), .TIMEOUT_CYCLES(TOC)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .cpu_ce(cpu_ce), .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_hold(cpu_hold),
      .hs_access(hs_access), .hs_address(hs_address), .hs_data_in(hs_data_in),
      .hs_write(hs_write), .hs_data_out(hs_data_out), .hs_ready(hs_ready),
      .hs_timeout(hs_timeout)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct { logic [DW-1:0] d; int a; } exp_t;
   exp_t q_cpu[$], q_hs[$];
   logic [DW-1:0] mdl [0:(1<<AW)-1];
   int la[$];
   int checks = 0, failures = 0;
   logic rd_cpu = 1'b0, rd_hs = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Monitor: a read issued in one cycle is due on the next; compare against queued model data.
   initial begin
      logic dc, dh;
      exp_t e;
      forever begin
         @(posedge clk_sys);
         dc = rd_cpu; dh = rd_hs;
         @(negedge clk_sys);
         if (dc) begin
            if (q_cpu.size() == 0) chk("cpu_sb_underflow", 1, 0);
            else begin e = q_cpu.pop_front(); chk($sformatf("cpu_dout@%0h", e.a), 32'(cpu_dout), 32'(e.d)); end
         end
         if (dh) begin
            if (q_hs.size() == 0) chk("hs_sb_underflow", 1, 0);
            else begin e = q_hs.pop_front(); chk($sformatf("hs_data_out@%0h", e.a), 32'(hs_data_out), 32'(e.d)); end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_sys); #1;
   endtask

   task automatic cpu_wr(input int a, input logic [DW-1:0] d, input bit apply);
      cpu_addr = AW'(a); cpu_din = d; cpu_ce = 1; cpu_cs = 1; cpu_we = 1;
      tick();
      cpu_ce = 0; cpu_cs = 0; cpu_we = 0;
      if (apply) begin mdl[a] = d; la.push_back(a); end
   endtask

   task automatic cpu_rd(input int a);
      cpu_addr = AW'(a); cpu_ce = 1; cpu_cs = 1; cpu_we = 0;
      q_cpu.push_back('{mdl[a], a}); rd_cpu = 1;
      tick();
      rd_cpu = 0; cpu_ce = 0; cpu_cs = 0;
   endtask

   task automatic hs_wr(input int a, input logic [DW-1:0] d, input bit apply);
      hs_address = AW'(a); hs_data_in = d; hs_write = 1;
      tick();
      hs_write = 0;
      if (apply) begin mdl[a] = d; la.push_back(a); end
   endtask

   task automatic hs_rd(input int a);
      hs_address = AW'(a);
      q_hs.push_back('{mdl[a], a}); rd_hs = 1;
      tick();
      rd_hs = 0;
   endtask

   // Request ownership; CPU strobe lands 'pre' cycles after the request, grant due SETTLE+1 later.
   task automatic acquire(input string nm, input int pre, input bit cowr, input int ca, input logic [DW-1:0] cd);
      int n;
      hs_access = 1;
      if (cowr) begin cpu_addr = AW'(ca); cpu_din = cd; cpu_ce = 1; cpu_cs = 1; cpu_we = 1; end
      chk({nm, "_hold_pre"}, 32'(cpu_hold), 0);
      tick();
      cpu_ce = 0; cpu_cs = 0; cpu_we = 0;
      if (cowr) begin mdl[ca] = cd; la.push_back(ca); end
      chk({nm, "_hold_next"}, 32'(cpu_hold), 1);
      repeat (pre - 1) tick();
      cpu_ce = 1;
      tick();
      cpu_ce = 0;
      n = 1;
      while (!hs_ready && n < 20) begin tick(); n++; end
      chk({nm, "_grant_lat"}, 32'(n), SETTLE + 1);
   endtask

   task automatic release_chk(input string nm);
      hs_access = 0;
      tick();
      chk({nm, "_rel_ready"}, 32'(hs_ready), 0);
      chk({nm, "_rel_hold"}, 32'(cpu_hold), 1);
      tick();
      chk({nm, "_idle_hold"}, 32'(cpu_hold), 0);
   endtask

   initial begin
      int a, ca, n;
      logic [DW-1:0] d, cd;
      reset = 1; cpu_ce = 0; cpu_cs = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
      hs_access = 0; hs_address = '0; hs_data_in = '0; hs_write = 0;
      repeat (3) tick();
      chk("rst_hold", 32'(cpu_hold), 0);
      chk("rst_ready", 32'(hs_ready), 0);
      chk("rst_timeout", 32'(hs_timeout), 0);
      chk("rst_cpu_dout", 32'(cpu_dout), 0);
      chk("rst_hs_dout", 32'(hs_data_out), 0);
      reset = 0;
      tick();

      cpu_wr(12'h010, 8'($urandom), 1);
      cpu_wr(12'h020, 8'($urandom), 1);
      cpu_wr(12'h7FF, 8'($urandom), 1);
      for (int i = 0; i < 6; i++) cpu_wr(int'($urandom_range(0, 2047)), 8'($urandom), 1);
      for (int i = 0; i < 4; i++) cpu_rd(la[$urandom_range(0, la.size() - 1)]);

      // Handoff with a coincident CPU write, then hiscore read/write and gating in GRANT
      ca = int'($urandom_range(0, 2047)); cd = 8'($urandom);
      acquire("handoff", 3, 1, ca, cd);
      chk("handoff_ready", 32'(hs_ready), 1);
      hs_wr(12'h7FF, 8'hA5, 1);
      hs_rd(12'h7FF);
      cpu_wr(12'h010, 8'h3C, 0);
      hs_rd(12'h010);
      hs_wr(int'($urandom_range(0, 2047)), 8'($urandom), 1);
      hs_rd(la[$urandom_range(0, la.size() - 1)]);
      release_chk("rw");
      cpu_rd(12'h7FF);
      cpu_rd(ca);
      hs_wr(12'h020, 8'($urandom), 0);
      cpu_rd(12'h020);
      cpu_rd(12'h010);

      // Abort during DRAIN, just after the CPU strobe
      hs_access = 1;
      tick();
      chk("abort_hold", 32'(cpu_hold), 1);
      cpu_ce = 1;
      tick();
      cpu_ce = 0; hs_access = 0;
      chk("abort_ready_drain", 32'(hs_ready), 0);
      tick();
      chk("abort_rel_ready", 32'(hs_ready), 0);
      chk("abort_rel_hold", 32'(cpu_hold), 1);
      tick();
      chk("abort_idle_hold", 32'(cpu_hold), 0);
      chk("abort_idle_ready", 32'(hs_ready), 0);

      // Reset while granted
      acquire("rstg", int'($urandom_range(1, 3)), 0, 0, '0);
      a = int'($urandom_range(0, 2047)); d = 8'($urandom);
      hs_wr(a, d, 1);
      reset = 1; hs_access = 0;
      tick();
      chk("rstg_hold", 32'(cpu_hold), 0);
      chk("rstg_ready", 32'(hs_ready), 0);
      chk("rstg_hs_dout", 32'(hs_data_out), 0);
      reset = 0;
      tick();
      cpu_rd(a);

      // Randomized ownership rounds
      for (int r = 0; r < 4; r++) begin
         acquire($sformatf("rnd%0d", r), int'($urandom_range(1, 3)), $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 2047)), 8'($urandom));
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(0, 1) == 1) hs_wr(int'($urandom_range(0, 2047)), 8'($urandom), 1);
            else hs_rd(la[$urandom_range(0, la.size() - 1)]);
         end
         release_chk($sformatf("rnd%0d", r));
         for (int k = 0; k < 2; k++) cpu_rd(la[$urandom_range(0, la.size() - 1)]);
      end

`ifdef HISCORE_RAM_PORT_TIMEOUT_EN
      hs_access = 1;
      n = 0;
      while (!hs_timeout && n < 40) begin tick(); n++; end
      chk("to_latency", 32'(n), TOC + 1);
      chk("to_rel_ready", 32'(hs_ready), 0);
      chk("to_rel_hold", 32'(cpu_hold), 1);
      repeat (3) tick();
      chk("to_no_regrant_hold", 32'(cpu_hold), 0);
      chk("to_sticky", 32'(hs_timeout), 1);
      hs_access = 0;
      tick();
      chk("to_clear", 32'(hs_timeout), 0);
`else
      n = 0;
      chk("no_timeout", 32'(hs_timeout), 0);
`endif

      repeat (3) tick();
      chk("cpu_sb_drained", 32'(q_cpu.size()), 0);
      chk("hs_sb_drained", 32'(q_hs.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
